// File: rtl/spi_reg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_ctrl_pkg
//  Description : Shared types and constants for the SPI register command
//                sequencer: state encoding, command byte field positions and
//                the default read-turnaround byte.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_reg_ctrl_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,  // frame not active
        ST_CMD     = 3'd1,  // frame open, waiting for the command byte
        ST_RD_TURN = 3'd2,  // byte after a read command (turnaround slot)
        ST_RD_DATA = 3'd3,  // streaming read data
        ST_WR_DATA = 3'd4   // streaming write data
    } state_t;

    // Command byte layout: {rw, addr[6:0]}, rw = 1 means read
    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_ADDR_MSB = 6;

    // Byte shifted out during the read turnaround slot
    localparam logic [7:0] TURN_BYTE_DEFAULT = 8'h00;

endpackage
`default_nettype wire

// File: rtl/spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_ctrl
//  Description : Byte-level command sequencer between the SPI slave byte
//                engine and the register file. Decodes a command byte, then
//                performs auto-incrementing writes or prefetched reads, and
//                returns {cmd_err, status_in} as the first byte of each frame.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_reg_ctrl
    import spi_reg_ctrl_pkg::*;
#(
    parameter int         REG_COUNT = 64,
    parameter logic [7:0] TURN_BYTE = TURN_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ssel_active,
    input  logic       byte_done,
    input  logic [7:0] rx_byte,
    output logic [7:0] tx_byte,
    input  logic [6:0] status_in,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       cmd_err
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t     r_state;
    logic       r_ssel_q;       // previous ssel_active, for rising-edge detect
    logic [6:0] r_addr;         // address of the next write / current prefetch
    logic [7:0] r_tx;
    logic [7:0] r_prefetch;
    logic [6:0] r_reg_addr;
    logic [7:0] r_wdata;
    logic       r_wr;
    logic       r_rd;
    logic       r_rd_inv;       // the read being issued targets an invalid address
    logic       r_rd_d;         // reg_rdata is valid this cycle
    logic       r_rd_inv_d;
    logic       r_cmd_err;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic       w_ssel_rise;
    logic       w_cmd_rd;
    logic [6:0] w_cmd_addr;
    logic [6:0] w_addr_inc;
    logic       w_cmd_ok;
    logic       w_cur_ok;
    logic       w_inc_ok;

    function automatic logic addr_ok(input logic [6:0] a);
        return ({25'd0, a} < 32'(REG_COUNT));
    endfunction

    assign w_ssel_rise = ssel_active & ~r_ssel_q;
    assign w_cmd_rd    = rx_byte[CMD_RW_BIT];
    assign w_cmd_addr  = rx_byte[CMD_ADDR_MSB:0];
    assign w_addr_inc  = r_addr + 7'd1;          // wraps 127 -> 0
    assign w_cmd_ok    = addr_ok(w_cmd_addr);
    assign w_cur_ok    = addr_ok(r_addr);
    assign w_inc_ok    = addr_ok(w_addr_inc);

    // Frame sequencer: state, strobes, prefetch and transmit byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            // Reset to 1 so a frame already open at reset release is not
            // mistaken for a new frame; only a genuine rising edge starts one.
            r_ssel_q   <= 1'b1;
            r_addr     <= 7'd0;
            r_tx       <= 8'h00;
            r_prefetch <= 8'h00;
            r_reg_addr <= 7'd0;
            r_wdata    <= 8'h00;
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_rd_inv   <= 1'b0;
            r_rd_d     <= 1'b0;
            r_rd_inv_d <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_ssel_q   <= ssel_active;
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_rd_inv   <= 1'b0;
            r_rd_d     <= r_rd;
            r_rd_inv_d <= r_rd_inv;

            // Register file answers one cycle after the read strobe
            if (r_rd_d) begin
                r_prefetch <= r_rd_inv_d ? 8'h00 : reg_rdata;
            end

            if (!ssel_active) begin
                // Frame end wins over a coincident byte_done
                r_state <= ST_IDLE;
            end else if (w_ssel_rise) begin
                r_state   <= ST_CMD;
                r_tx      <= {r_cmd_err, status_in};
                r_cmd_err <= 1'b0;
            end else if (byte_done) begin
                case (r_state)
                    ST_CMD: begin
                        r_addr <= w_cmd_addr;
                        if (w_cmd_rd) begin
                            r_state    <= ST_RD_TURN;
                            r_tx       <= TURN_BYTE;
                            r_reg_addr <= w_cmd_addr;
                            r_rd       <= 1'b1;
                            r_rd_inv   <= ~w_cmd_ok;
                            if (!w_cmd_ok) r_cmd_err <= 1'b1;
                        end else begin
                            r_state <= ST_WR_DATA;
                            r_tx    <= 8'h00;
                        end
                    end
                    ST_RD_TURN, ST_RD_DATA: begin
                        r_state    <= ST_RD_DATA;
                        r_tx       <= r_prefetch;
                        r_addr     <= w_addr_inc;
                        r_reg_addr <= w_addr_inc;
                        r_rd       <= 1'b1;
                        r_rd_inv   <= ~w_inc_ok;
                        if (!w_inc_ok) r_cmd_err <= 1'b1;
                    end
                    ST_WR_DATA: begin
                        r_tx       <= 8'h00;
                        r_reg_addr <= r_addr;
                        r_wdata    <= rx_byte;
                        r_wr       <= w_cur_ok;
                        r_addr     <= w_addr_inc;
                        if (!w_cur_ok) r_cmd_err <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign tx_byte   = r_tx;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_wdata;
    assign reg_wr    = r_wr;
    assign reg_rd    = r_rd;
    assign cmd_err   = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_reg_ctrl
//  Description : Self-checking bench for spi_reg_ctrl. Two instances run in
//                lockstep (REG_COUNT 64 / default turn byte, REG_COUNT 128 /
//                turn byte A5) against a frame-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_reg_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ssel_active;
    logic       byte_done;
    logic [7:0] rx_byte;
    logic [6:0] status_in;
    logic [7:0] tx_byte   [2];
    logic [6:0] reg_addr  [2];
    logic [7:0] reg_wdata [2];
    logic       reg_wr    [2];
    logic       reg_rd    [2];
    logic [7:0] reg_rdata [2];
    logic       cmd_err   [2];

    spi_reg_ctrl #(.REG_COUNT(64)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .ssel_active(ssel_active), .byte_done(byte_done),
        .rx_byte(rx_byte), .tx_byte(tx_byte[0]), .status_in(status_in),
        .reg_addr(reg_addr[0]), .reg_wdata(reg_wdata[0]), .reg_wr(reg_wr[0]),
        .reg_rd(reg_rd[0]), .reg_rdata(reg_rdata[0]), .cmd_err(cmd_err[0])
    );

    spi_reg_ctrl #(.REG_COUNT(128), .TURN_BYTE(8'hA5)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ssel_active(ssel_active), .byte_done(byte_done),
        .rx_byte(rx_byte), .tx_byte(tx_byte[1]), .status_in(status_in),
        .reg_addr(reg_addr[1]), .reg_wdata(reg_wdata[1]), .reg_wr(reg_wr[1]),
        .reg_rd(reg_rd[1]), .reg_rdata(reg_rdata[1]), .cmd_err(cmd_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file environment: data appears exactly one cycle after reg_rd,
    // random garbage otherwise.
    logic [7:0] mem     [2][128];
    logic [7:0] ref_mem [2][128];
    logic       mem_load;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_load) begin
                for (int a = 0; a < 128; a++) mem[k][a] <= ref_mem[k][a];
            end else if (reg_wr[k]) begin
                mem[k][reg_addr[k]] <= reg_wdata[k];
            end
            if (reg_rd[k]) reg_rdata[k] <= mem[k][reg_addr[k]];
            else           reg_rdata[k] <= 8'($urandom);
        end
    end

    int         n_checks;
    int         n_fail;
    logic [7:0] fb   [$];   // bytes the host sends in a frame
    logic [7:0] got0 [$];   // bytes the host received from each DUT
    logic [7:0] got1 [$];
    logic [15:0] wlog[$];   // {dut, addr, data} of every observed write
    logic       ref_err [2];

    function automatic logic [7:0] turn_of(input int k);
        return (k == 0) ? 8'h00 : 8'hA5;
    endfunction

    task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // One clock, then observe strobes just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (reg_wr[k]) wlog.push_back({1'(k), reg_addr[k], reg_wdata[k]});
            if (reg_wr[k] || reg_rd[k])
                chk("strobe_exclusive", k, 16'(reg_wr[k] & reg_rd[k]), 16'h0);
        end
    endtask

    // Send fb as one frame. With coinc set, the last byte_done lands in the
    // same cycle that ssel_active falls.
    task automatic run_frame(input bit coinc);
        got0.delete();
        got1.delete();
        tick();
        ssel_active = 1'b1;
        for (int i = 0; i < fb.size(); i++) begin
            repeat (16) tick();
            byte_done = 1'b1;
            rx_byte   = fb[i];
            got0.push_back(tx_byte[0]);
            got1.push_back(tx_byte[1]);
            if (coinc && i == fb.size() - 1) ssel_active = 1'b0;
            tick();
            byte_done = 1'b0;
            rx_byte   = 8'($urandom);
        end
        repeat (8) tick();
        ssel_active = 1'b0;
        repeat (4) tick();
    endtask

    // Reference: derive expected MISO bytes, writes and error flag from the
    // frame contents and the model register file.
    task automatic check_frame(input string nm, input bit coinc);
        int nrx, rc, a0, a;
        logic [7:0]  em [$];
        logic [7:0]  gq [$];
        logic [14:0] ew [$];
        logic [14:0] aw [$];
        nrx = fb.size() - 1 - (coinc ? 1 : 0);
        a0  = int'(fb[0][6:0]);
        for (int k = 0; k < 2; k++) begin
            rc = (k == 0) ? 64 : 128;
            em.delete(); ew.delete(); aw.delete();
            em.push_back({ref_err[k], status_in});
            ref_err[k] = 1'b0;
            for (int i = 1; i < fb.size(); i++) begin
                if (!fb[0][7])  em.push_back(8'h00);
                else if (i == 1) em.push_back(turn_of(k));
                else begin
                    a = (a0 + i - 2) % 128;
                    em.push_back(a < rc ? ref_mem[k][a] : 8'h00);
                end
            end
            if (nrx >= 0) begin
                if (fb[0][7]) begin
                    for (int j = 0; j <= nrx; j++)
                        if ((a0 + j) % 128 >= rc) ref_err[k] = 1'b1;
                end else begin
                    for (int i = 1; i <= nrx; i++) begin
                        a = (a0 + i - 1) % 128;
                        if (a < rc) begin
                            ref_mem[k][a] = fb[i];
                            ew.push_back({7'(a), fb[i]});
                        end else begin
                            ref_err[k] = 1'b1;
                        end
                    end
                end
            end
            gq = (k == 0) ? got0 : got1;
            chk({nm, "_miso_count"}, k, 16'(gq.size()), 16'(em.size()));
            for (int i = 0; i < em.size() && i < gq.size(); i++)
                chk($sformatf("%s_miso%0d", nm, i), k, 16'(gq[i]), 16'(em[i]));
            foreach (wlog[i]) if (wlog[i][15] == 1'(k)) aw.push_back(wlog[i][14:0]);
            chk({nm, "_wr_count"}, k, 16'(aw.size()), 16'(ew.size()));
            for (int i = 0; i < ew.size() && i < aw.size(); i++)
                chk($sformatf("%s_wr%0d", nm, i), k, 16'(aw[i]), 16'(ew[i]));
            chk({nm, "_cmd_err"}, k, 16'(cmd_err[k]), 16'(ref_err[k]));
        end
        wlog.delete();
    endtask

    typedef struct {
        logic [7:0] b [6];   // command + data bytes
        int         nb;
        logic [6:0] st;      // status_in for the frame
        logic [7:0] e [6];   // expected MISO of the REG_COUNT=64 instance
    } vec_t;

    vec_t vt [6];

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; ssel_active = 1'b0; byte_done = 1'b0;
        rx_byte = 8'h00; status_in = 7'h00; mem_load = 1'b1;
        ref_err[0] = 1'b0; ref_err[1] = 1'b0;

        for (int a = 0; a < 128; a++) begin
            ref_mem[0][a] = 8'($urandom);
            ref_mem[1][a] = ref_mem[0][a];
        end
        for (int k = 0; k < 2; k++) begin
            ref_mem[k][10] = 8'hA1; ref_mem[k][11] = 8'hB2; ref_mem[k][12] = 8'hC3;
            ref_mem[k][0] = 8'h5C;  ref_mem[k][1] = 8'h6D;  ref_mem[k][127] = 8'hE7;
        end

        vt[0] = '{b:'{8'h05,8'h11,8'h22,8'h00,8'h00,8'h00}, nb:3, st:7'h2A, e:'{8'h2A,8'h00,8'h00,8'h00,8'h00,8'h00}};
        vt[1] = '{b:'{8'h8A,8'h00,8'h00,8'h00,8'h00,8'h00}, nb:5, st:7'h15, e:'{8'h15,8'h00,8'hA1,8'hB2,8'hC3,8'h00}};
        vt[2] = '{b:'{8'h3F,8'h55,8'h66,8'h00,8'h00,8'h00}, nb:3, st:7'h01, e:'{8'h01,8'h00,8'h00,8'h00,8'h00,8'h00}};
        vt[3] = '{b:'{8'h85,8'h00,8'h00,8'h00,8'h00,8'h00}, nb:3, st:7'h02, e:'{8'h82,8'h00,8'h11,8'h00,8'h00,8'h00}};
        vt[4] = '{b:'{8'h01,8'h00,8'h00,8'h00,8'h00,8'h00}, nb:1, st:7'h03, e:'{8'h03,8'h00,8'h00,8'h00,8'h00,8'h00}};
        vt[5] = '{b:'{8'hFF,8'h00,8'h00,8'h00,8'h00,8'h00}, nb:5, st:7'h7F, e:'{8'h7F,8'h00,8'h00,8'h5C,8'h6D,8'h00}};

        // Reset values
        repeat (3) tick();
        mem_load = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("rst_tx",    k, 16'(tx_byte[k]),   16'h0);
            chk("rst_addr",  k, 16'(reg_addr[k]),  16'h0);
            chk("rst_wdata", k, 16'(reg_wdata[k]), 16'h0);
            chk("rst_wr",    k, 16'(reg_wr[k]),    16'h0);
            chk("rst_rd",    k, 16'(reg_rd[k]),    16'h0);
            chk("rst_err",   k, 16'(cmd_err[k]),   16'h0);
        end
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Directed frames from the table
        for (int v = 0; v < 6; v++) begin
            status_in = vt[v].st;
            fb.delete();
            for (int i = 0; i < vt[v].nb; i++) fb.push_back(vt[v].b[i]);
            run_frame(1'b0);
            check_frame($sformatf("vec%0d", v), 1'b0);
            for (int i = 0; i < vt[v].nb && i < got0.size(); i++)
                chk($sformatf("vec%0d_table%0d", v, i), 0, 16'(got0[i]), 16'(vt[v].e[i]));
        end

        // Abort mid data byte, then frame end coincident with byte_done
        status_in = 7'h11;
        fb.delete(); fb.push_back(8'h05);
        run_frame(1'b0);
        check_frame("abort_partial", 1'b0);
        fb.delete(); fb.push_back(8'h07); fb.push_back(8'h99);
        run_frame(1'b1);
        check_frame("abort_coinc", 1'b1);
        fb.delete(); fb.push_back(8'h07); fb.push_back(8'h3C);
        run_frame(1'b0);
        check_frame("after_abort", 1'b0);

        // Randomized frames, biased toward the REG_COUNT boundary and the wrap
        for (int f = 0; f < 30; f++) begin
            int nb;
            logic [7:0] cmd;
            bit coinc;
            nb  = $urandom_range(1, 6);
            cmd = 8'($urandom);
            if ($urandom_range(0, 2) == 0) cmd[6:0] = 7'(60 + $urandom_range(0, 7));
            else if ($urandom_range(0, 3) == 0) cmd[6:0] = 7'(125 + $urandom_range(0, 2));
            fb.delete();
            fb.push_back(cmd);
            for (int i = 1; i < nb; i++) fb.push_back(8'($urandom));
            coinc = (nb >= 2) && ($urandom_range(0, 4) == 0);
            status_in = 7'($urandom);
            run_frame(coinc);
            check_frame($sformatf("rand%0d", f), coinc);
        end

        // Reset in the middle of a read that has set cmd_err on dut0
        wlog.delete();
        status_in = 7'h33;
        tick();
        ssel_active = 1'b1;
        repeat (16) tick();
        byte_done = 1'b1; rx_byte = 8'hC1;
        tick();
        byte_done = 1'b0;
        repeat (16) tick();
        byte_done = 1'b1; rx_byte = 8'h00;
        tick();
        byte_done = 1'b0;
        repeat (3) tick();
        chk("pre_reset_err", 0, 16'(cmd_err[0]), 16'h1);
        #3 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("midrst_tx",    k, 16'(tx_byte[k]),   16'h0);
            chk("midrst_wr",    k, 16'(reg_wr[k]),    16'h0);
            chk("midrst_rd",    k, 16'(reg_rd[k]),    16'h0);
            chk("midrst_err",   k, 16'(cmd_err[k]),   16'h0);
            chk("midrst_addr",  k, 16'(reg_addr[k]),  16'h0);
            chk("midrst_wdata", k, 16'(reg_wdata[k]), 16'h0);
        end
        ref_err[0] = 1'b0; ref_err[1] = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        // Bytes in a frame that was open across reset must be ignored
        repeat (4) tick();
        byte_done = 1'b1; rx_byte = 8'h05;
        tick();
        byte_done = 1'b0;
        repeat (16) tick();
        byte_done = 1'b1; rx_byte = 8'h11;
        tick();
        byte_done = 1'b0;
        repeat (8) tick();
        ssel_active = 1'b0;
        repeat (4) tick();
        for (int k = 0; k < 2; k++) begin
            int nw;
            nw = 0;
            foreach (wlog[i]) if (wlog[i][15] == 1'(k)) nw++;
            chk("resumed_no_wr", k, 16'(nw), 16'h0);
            chk("resumed_tx",    k, 16'(tx_byte[k]), 16'h0);
        end
        wlog.delete();
        status_in = 7'h44;
        fb.delete(); fb.push_back(8'h8A); fb.push_back(8'h00); fb.push_back(8'h00); fb.push_back(8'h00);
        run_frame(1'b0);
        check_frame("post_reset", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Byte-level command sequencer that sits between the SPI slave byte engine and the FPGA register file. It parses each SSEL-framed SPI transaction as a command byte followed by data bytes, then issues auto-incrementing register reads or writes. It also prefetches read data so that the transmit byte is always ready before the SPI slave latches it. Error and status reporting goes back to the host in the first byte of every frame.

## Interface
- `REG_COUNT`, default 64: number of implemented registers; addresses ≥ `REG_COUNT` are invalid.
- `TURN_BYTE`, default 8'h00: byte returned during the read turnaround slot.

Ports:
- `clk`  in  1  system clock; same clock as the SPI slave.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ssel_active`  in  1  synchronized frame-active from the SPI slave (high while SSEL is low).
- `byte_done`  in  1  one-cycle pulse from the SPI slave at each byte boundary.
- `rx_byte`  in  8  received byte; valid in the `byte_done` cycle.
- `tx_byte`  out  8  byte to shift next; drives the SPI slave `DATA_OUT`.
- `status_in`  in  7  system status; sampled at frame start.
- `reg_addr`  out  7  register address.
- `reg_wdata`  out  8  write data.
- `reg_wr`  out  1  one-cycle write strobe.
- `reg_rd`  out  1  one-cycle read strobe.
- `reg_rdata`  in  8  read data; valid exactly 1 cycle after `reg_rd`.
- `cmd_err`  out  1  sticky flag: an invalid address was accessed in the current or last frame.

## Operation
- Frame format: byte0 = command {rw (bit7, 1 = read), addr[6:0]}, then N data bytes. The address increments after each data byte and wraps 127 → 0.
- States:
  - **IDLE**: `ssel_active` low.
  - **CMD**: frame open, awaiting byte0.
  - **RD_TURN**: byte1 of a read.
  - **RD_DATA**: read data bytes.
  - **WR_DATA**: write data bytes.
- Transitions:
  - IDLE → CMD on the rising edge of `ssel_active`. On that edge, `tx_byte` ← {`cmd_err`, `status_in`} and `cmd_err` clears.
  - CMD → WR_DATA or RD_TURN on `byte_done`, per rw. Store addr.
  - RD_TURN → RD_DATA on `byte_done`.
  - Any state → IDLE when `ssel_active` goes low, within 1 cycle. A partial byte is discarded and no strobe is issued.
- Write: each `byte_done` in WR_DATA causes `reg_wr` to assert the next cycle with the current addr and `reg_wdata` = `rx_byte`; addr then increments.
- Read prefetch:
  - On CMD → RD_TURN, issue `reg_rd` (addr) and capture `reg_rdata` into an 8-bit prefetch register.
  - The `tx_byte` for the byte following the command is `TURN_BYTE`.
  - On each `byte_done` in RD_TURN or RD_DATA: `tx_byte` ← prefetch, addr increments, then `reg_rd` is issued at the new addr to refill the prefetch.
- Invalid addr (≥ `REG_COUNT`):
  - Write strobe is suppressed.
  - Prefetch loads 8'h00.
  - `cmd_err` sets.
- In WR_DATA and CMD, `tx_byte` holds 8'h00 after byte0.

## Timing
- Reset values:
  - state IDLE
  - `tx_byte` 8'h00
  - `reg_addr` 0
  - `reg_wdata` 0
  - `reg_wr` 0
  - `reg_rd` 0
  - `cmd_err` 0
  - prefetch 0
- `tx_byte` updates exactly 1 cycle after `byte_done` and is then stable until the next `byte_done`. The SPI slave loads `DATA_OUT` 2 cycles after its DONE, so this meets its load window.
- `reg_wr`/`reg_rd` are 1-cycle pulses: at most one per `byte_done`, never both in the same cycle.
- Latencies:
  - `byte_done` → `reg_wr`: 1 cycle.
  - `byte_done` → next `reg_rd`: 1 cycle.
  - `reg_rd` → prefetch valid: 2 cycles.
  - The prefetch is complete well inside one byte time (≥ 16 clk at the minimum SCK ratio).
- If `byte_done` and the falling edge of `ssel_active` occur in the same cycle, the frame end wins and no strobe is issued.
- Mid-frame reset: all outputs go to their reset values immediately. The frame is resumed only on the next `ssel_active` rising edge.

## Structure
- The shared package holds:
  - State encoding (`ST_IDLE`, `ST_CMD`, `ST_RD_TURN`, `ST_RD_DATA`, `ST_WR_DATA`).
  - Command field positions (`CMD_RW_BIT` = 7, `CMD_ADDR_MSB` = 6).
  - `TURN_BYTE` default.
- A single module; no sub-modules. The SPI slave is instantiated beside it at the top level.

## Test plan
- Write frame: cmd 8'h05, data 8'h11, 8'h22 → `reg_wr` at addr 5 with 8'h11, then at addr 6 with 8'h22; host MISO stream = {status}, 00, 00.
- Read frame: regs 10/11/12 = 8'hA1/B2/C3; cmd 8'h8A followed by 4 dummy bytes → host receives status, 00 (turn), A1, B2, C3.
- Invalid access with `REG_COUNT` = 64: cmd 8'h3F write 8'h55, 8'h66 → write at 63 only, no strobe at 64; next frame's byte0 has bit7 = 1; the following frame's byte0 has bit7 = 0.
- Wrap: `REG_COUNT` = 128, read from 8'hFF with 3 data bytes → reads addr 127, 0, 1.
- Abort: drop `ssel_active` after 4 SCK edges of a write data byte → no `reg_wr`; state IDLE within 1 cycle; the next frame decodes normally.
- Assert `rst_n` low mid-read → `tx_byte` = 00 and strobes low immediately; a new frame after release returns correct status and data.
